fp_issue_ctrl: RTL

//  Issue/sequencing controller for the FP coprocessor. Sits between decode (fp_operation, fp_reg_write,
//  fp_reg_read, move_fp_to_cpu, move_cpu_to_fp) and a non-pipelined multi-cycle FPU. Launches one FP op
//  at a time, tracks its pending destination, and stalls dependent instructions (RAW/WAW, FP-load/MTC1/MFC1/SWC1).

---
 rtl/fp_issue_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issue/sequencing controller for the FP coprocessor.
// Launches one FP arithmetic op at a time into a non-pipelined multi-cycle FPU,
// tracks its pending destination, stalls dependent or conflicting instructions,
// and arbitrates the single FP register-file write port.
//
// Optional feature macro: FP_DIV_EN (defined: funct 000011 div is issued;
// undefined: div is dropped with an fp_illegal pulse).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   issue_valid                    decoded instruction present
//   fp_operation, fp_reg_write,    decode class flags (FP op, FP reg write,
//   fp_reg_read, move_fp_to_cpu,   SWC1, MFC1, MTC1)
//   move_cpu_to_fp
//   fp_funct, fs, ft, fd           funct and register specifiers
//   fpu_done                       FPU result valid pulse
//   stall                          decode hold (combinational)
//   fpu_start, fpu_funct           registered launch pulse and funct to FPU
//   fp_wb_en, fp_wb_sel_fpu,       FP regfile write port control (combinational)
//   fp_wb_addr
//   fp_busy                        op in flight (EXEC or WB)
//   fp_illegal                     registered pulse: unsupported funct dropped
//   fp_error                       sticky watchdog expiry
module fp_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       fp_operation,
  input  logic       fp_reg_write,
  input  logic       fp_reg_read,
  input  logic       move_fp_to_cpu,
  input  logic       move_cpu_to_fp,
  input  logic [5:0] fp_funct,
  input  logic [4:0] fs,
  input  logic [4:0] ft,
  input  logic [4:0] fd,
  input  logic       fpu_done,
  output logic       stall,
  output logic       fpu_start,
  output logic [5:0] fpu_funct,
  output logic       fp_wb_en,
  output logic       fp_wb_sel_fpu,
  output logic [4:0] fp_wb_addr,
  output logic       fp_busy,
  output logic       fp_illegal,
  output logic       fp_error
);

  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;

`ifdef FP_DIV_EN
  localparam logic [FUNCT_W-1:0] MAX_FUNCT = FUNCT_W'(3);
`else
  localparam logic [FUNCT_W-1:0] MAX_FUNCT = FUNCT_W'(2);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [REG_W-1:0]   pend_dest;
  logic [CNT_W-1:0]   wd_cnt;

  logic funct_legal, is_op, is_bad, is_mtc1, is_lwc1, is_swc1, is_mfc1;
  logic pend_valid, data_haz, struct_haz, accept, launch, load_wr, timeout;
  logic [REG_W-1:0] load_dest;

  // Instruction classification; decode flags are prioritised in case of overlap.
  assign funct_legal = fp_funct <= MAX_FUNCT;
  assign is_op   = fp_operation & funct_legal;
  assign is_bad  = fp_operation & ~funct_legal;
  assign is_mtc1 = ~fp_operation & move_cpu_to_fp;
  assign is_lwc1 = ~fp_operation & ~move_cpu_to_fp & fp_reg_write;
  assign is_swc1 = ~fp_operation & ~move_cpu_to_fp & ~fp_reg_write & fp_reg_read;
  assign is_mfc1 = ~fp_operation & ~move_cpu_to_fp & ~fp_reg_write & ~fp_reg_read & move_fp_to_cpu;
  assign load_dest = is_mtc1 ? fs : ft;

  // RAW/WAW against the in-flight destination, which stays live through WB.
  assign pend_valid = (state != IDLE);
  assign data_haz = pend_valid &
                    ((is_op   & ((fs == pend_dest) | (ft == pend_dest) | (fd == pend_dest))) |
                     (is_mtc1 & (fs == pend_dest)) |
                     (is_lwc1 & (ft == pend_dest)) |
                     (is_swc1 & (ft == pend_dest)) |
                     (is_mfc1 & (fs == pend_dest)));
  // FPU busy in EXEC; write port owned by the FPU result in WB.
  assign struct_haz = (is_op & (state == EXEC)) | ((is_mtc1 | is_lwc1) & (state == WB));

  assign stall   = issue_valid & (data_haz | struct_haz);
  assign accept  = issue_valid & ~stall;
  assign launch  = accept & is_op;
  assign load_wr = accept & (is_mtc1 | is_lwc1);
  // Done on the last allowed cycle still wins over expiry.
  assign timeout = (state == EXEC) & ~fpu_done & (wd_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = EXEC;
      EXEC:    if (fpu_done) state_nxt = WB;
               else if (timeout) state_nxt = IDLE;
      WB:      state_nxt = launch ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write-port arbitration and busy flag.
  always_comb begin
    fp_wb_en      = 1'b0;
    fp_wb_sel_fpu = 1'b0;
    fp_wb_addr    = '0;
    fp_busy       = (state != IDLE);
    if (state == WB) begin
      fp_wb_en      = 1'b1;
      fp_wb_sel_fpu = 1'b1;
      fp_wb_addr    = pend_dest;
    end else if (load_wr) begin
      fp_wb_en   = 1'b1;
      fp_wb_addr = load_dest;
    end
  end

  // Launch, pending destination, watchdog and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dest  <= '0;
      wd_cnt     <= '0;
      fpu_start  <= 1'b0;
      fpu_funct  <= '0;
      fp_illegal <= 1'b0;
      fp_error   <= 1'b0;
    end else begin
      fpu_start  <= launch;
      fp_illegal <= issue_valid & is_bad;
      if (timeout) fp_error <= 1'b1;
      if (launch) begin
        pend_dest <= fd;
        fpu_funct <= fp_funct;
      end else if ((state == WB) || timeout) begin
        pend_dest <= '0;
      end
      if (launch || (state != EXEC)) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule
